decode_cycle: RTL and testbench
===============================

// Module: decode_cycle
// PURPOSE
//  Decode stage of the 5-stage RV32I pipeline; sole consumer of the fetch stage's InstrD/PCD/PCPlus4D.
//  Decodes control, reads the 32x32 register file, sign-extends immediates and registers everything into the D->E pipeline register.
//  Register file is written from the writeback stage. FlushE (taken branch/jump from execute) turns the issued instruction into a bubble.
// PARAMETERS
//  XLEN     32  datapath width
//  NREGS    32  architectural registers (x0 hardwired zero)
// PORTS
//  clk         in   1     rising-edge clock, single clock domain
//  rst         in   1     synchronous, active-high reset
//  InstrD      in   32    instruction from fetch
//  PCD         in   32    PC of InstrD
//  PCPlus4D    in   32    PCD+4
//  FlushE      in   1     squash: load bubble into E regs
//  RegWriteW   in   1     writeback enable
//  RDW         in   5     writeback destination
//  ResultW     in   32    writeback data
//  RegWriteE   out  1     reg-write control
//  ResultSrcE  out  2     00 ALU, 01 mem, 10 PC+4
//  MemWriteE   out  1     store
//  JumpE       out  1     jal
//  BranchE     out  1     beq
//  ALUControlE out  3     000 add,001 sub,010 and,011 or,101 slt
//  ALUSrcE     out  1     0 RD2E, 1 ImmExtE
//  RD1E,RD2E   out  32    operand registers
//  ImmExtE     out  32    sign-extended immediate
//  RS1E,RS2E,RDE out 5    register indices (for hazard unit)
//  PCE,PCPlus4E out 32    forwarded PCs
// BEHAVIOUR
//  - Latency: exactly 1 cycle D->E; every output is a flop updated each rising edge (no stall input).
//  - rst: all outputs 0 next edge; all 32 registers cleared to 0. Reset mid-stream discards the in-flight instruction.
//  - FlushE=1 (rst=0): RegWriteE,MemWriteE,JumpE,BranchE,ResultSrcE,ALUControlE,ALUSrcE <= 0; data/index outputs also <= 0.
//    rst has priority over FlushE.
//  - Opcodes: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 beq, 1101111 jal.
//    Any other opcode -> all controls 0 (NOP), ImmExt 0.
//  - ALU decode: lw/sw add; beq sub; R/I by funct3 {000 add (sub if R and funct7[5]),010 slt,110 or,111 and}; others add.
//  - ImmSrc: I {Instr[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; J {[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31.
//  - Regfile: write at rising edge when RegWriteW && RDW!=0; writes to x0 ignored; reads of x0 return 0.
//    Same-cycle read of register being written returns ResultW (write-through bypass), never the stale value.
//  - RS1E/RS2E/RDE taken from Instr[19:15]/[24:20]/[11:7] regardless of format.
// STRUCTURE
//  - riscv_pkg: opcode constants, ALUControl codes, ResultSrc codes, ImmSrc codes.
//  - Sub-module register_file (2 async read ports + bypass, 1 sync write port, sync reset). Control decode, immediate extend and E regs inline.
// TESTING
//  - rst=1 two cycles -> all outputs 0; read any reg after -> 0.
//  - RegWriteW=1,RDW=5,ResultW=32'hDEADBEEF; same cycle InstrD=add x6,x5,x0 (32'h00028333) -> next edge RD1E=DEADBEEF, RegWriteE=1, ALUControlE=000, RDE=6.
//  - InstrD=lw x1,-4(x2) (32'hFFC12083) -> ImmExtE=FFFFFFFC, ResultSrcE=01, ALUSrcE=1, MemWriteE=0.
//  - InstrD=beq x1,x2,-8 (32'hFE208CE3) -> BranchE=1, ALUControlE=001, ImmExtE=FFFFFFF8. Also jal x1,+16 (32'h010000EF) -> JumpE=1, ResultSrcE=10, ImmExtE=00000010.
//  - FlushE=1 with sw in D -> next edge MemWriteE=0, all controls 0; FlushE and rst together -> reset values.
//  - RegWriteW=1,RDW=0,ResultW=1 -> read of x0 stays 0; illegal opcode 32'hFFFFFFFF -> all controls 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I decode constants, control codes and immediate extender
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_src_e;

    function automatic logic [XLEN-1:0] immExtend(input logic [31:0] instr, input imm_src_e immSrc);
        case (immSrc)
            IMM_I:   immExtend = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   immExtend = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   immExtend = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   immExtend = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immExtend = '0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two async reads with write-through bypass
module register_file
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      a1,
    input  logic [4:0]      a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we3,
    input  logic [4:0]      a3,
    input  logic [XLEN-1:0] wd3
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we3 && (a3 != 5'd0)) begin
            regs[a3] <= wd3;
        end
    end

    // A nonzero read address equal to a live write address forwards the write data.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != 5'd0) rd1 = (we3 && (a3 == a1)) ? wd3 : regs[a1];
        if (a2 != 5'd0) rd2 = (we3 && (a3 == a2)) ? wd3 : regs[a2];
    end

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: control decode, register read, immediate extend, D->E register
module decode_cycle
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RDE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD, aluFromFunct3;
    result_src_e     resultSrcD;
    alu_ctrl_e       aluControlD;
    imm_src_e        immSrcD;
    logic [XLEN-1:0] rd1D, rd2D, immExtD;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];

    register_file regFile (
        .clk (clk),
        .rst (rst),
        .a1  (InstrD[19:15]),
        .a2  (InstrD[24:20]),
        .rd1 (rd1D),
        .rd2 (rd2D),
        .we3 (RegWriteW),
        .a3  (RDW),
        .wd3 (ResultW)
    );

    always_comb begin
        regWriteD     = 1'b0;
        memWriteD     = 1'b0;
        jumpD         = 1'b0;
        branchD       = 1'b0;
        aluSrcD       = 1'b0;
        aluFromFunct3 = 1'b0;
        resultSrcD    = RES_ALU;
        aluControlD   = ALU_ADD;
        immSrcD       = IMM_NONE;
        case (opcode)
            OP_LOAD:   begin regWriteD = 1'b1; aluSrcD = 1'b1; resultSrcD = RES_MEM; immSrcD = IMM_I; end
            OP_STORE:  begin memWriteD = 1'b1; aluSrcD = 1'b1; immSrcD = IMM_S; end
            OP_RTYPE:  begin regWriteD = 1'b1; aluFromFunct3 = 1'b1; end
            OP_ITYPE:  begin regWriteD = 1'b1; aluSrcD = 1'b1; aluFromFunct3 = 1'b1; immSrcD = IMM_I; end
            OP_BRANCH: begin branchD = 1'b1; aluControlD = ALU_SUB; immSrcD = IMM_B; end
            OP_JAL:    begin regWriteD = 1'b1; jumpD = 1'b1; resultSrcD = RES_PC4; immSrcD = IMM_J; end
            default:   ;
        endcase
        // funct7[5] selects sub only for register-register ops; addi has no sub form.
        if (aluFromFunct3) begin
            case (funct3)
                3'b000:  aluControlD = (opcode == OP_RTYPE && InstrD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  aluControlD = ALU_SLT;
                3'b110:  aluControlD = ALU_OR;
                3'b111:  aluControlD = ALU_AND;
                default: aluControlD = ALU_ADD;
            endcase
        end
        immExtD = immExtend(InstrD, immSrcD);
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RS1E        <= '0;
            RS2E        <= '0;
            RDE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= regWriteD;
            ResultSrcE  <= resultSrcD;
            MemWriteE   <= memWriteD;
            JumpE       <= jumpD;
            BranchE     <= branchD;
            ALUControlE <= aluControlD;
            ALUSrcE     <= aluSrcD;
            RD1E        <= rd1D;
            RD2E        <= rd2D;
            ImmExtE     <= immExtD;
            RS1E        <= InstrD[19:15];
            RS2E        <= InstrD[24:20];
            RDE         <= InstrD[11:7];
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - directed self-checking bench for decode_cycle
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst, FlushE, RegWriteW;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RDE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
        .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    function automatic logic [11:0] ctrlBits();
        return {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, 1'b0};
    endfunction

    task automatic cycle(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        FlushE    = 1'b0;
        RegWriteW = 1'b0;
        RDW       = 5'd0;
        ResultW   = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; FlushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
        cycle(32'h00000013, 32'h0);
        RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h12345678;
        cycle(32'h00000013, 32'h100);
        rst = 1'b1;
        cycle(32'h00028333, 32'h104);
        rst = 1'b1;
        cycle(32'h00028333, 32'h108);
        checks++;
        if ({ctrlBits(), RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ctrl=%h RD1E=%h ImmExtE=%h RDE=%0d PCE=%h, required all zero",
                     ctrlBits(), RD1E, ImmExtE, RDE, PCE);
        end
        cycle(32'h00028333, 32'h10C);
        checks++;
        if (RD1E !== 32'd0 || RDE !== 5'd6 || RS1E !== 5'd5) begin
            errors++;
            $display("FAIL reset_clears_x5: RD1E=%h RS1E=%0d RDE=%0d, required 0/5/6", RD1E, RS1E, RDE);
        end
    endtask

    task automatic test_bypass();
        RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
        cycle(32'h00028333, 32'h200);
        checks++;
        if (RD1E !== 32'hDEADBEEF || RegWriteE !== 1'b1 || ALUControlE !== 3'b000 || RDE !== 5'd6
            || RD2E !== 32'd0 || ResultSrcE !== 2'b00 || ALUSrcE !== 1'b0) begin
            errors++;
            $display("FAIL bypass_add: RD1E=%h RegWriteE=%b ALU=%b RDE=%0d RD2E=%h, required DEADBEEF/1/000/6/0",
                     RD1E, RegWriteE, ALUControlE, RDE, RD2E);
        end
        checks++;
        if (PCE !== 32'h200 || PCPlus4E !== 32'h204) begin
            errors++;
            $display("FAIL pc_forward: PCE=%h PCPlus4E=%h, required 200/204", PCE, PCPlus4E);
        end
        cycle(32'h406283B3, 32'h204);
        checks++;
        if (ALUControlE !== 3'b001 || RD1E !== 32'hDEADBEEF || RDE !== 5'd7 || RS2E !== 5'd6) begin
            errors++;
            $display("FAIL sub_stored: ALU=%b RD1E=%h RDE=%0d RS2E=%0d, required 001/DEADBEEF/7/6",
                     ALUControlE, RD1E, RDE, RS2E);
        end
    endtask

    task automatic test_back_to_back();
        cycle(32'hFFC12083, 32'h300);
        checks++;
        if (ImmExtE !== 32'hFFFFFFFC || ResultSrcE !== 2'b01 || ALUSrcE !== 1'b1 || MemWriteE !== 1'b0
            || RegWriteE !== 1'b1 || ALUControlE !== 3'b000 || RS1E !== 5'd2 || RDE !== 5'd1) begin
            errors++;
            $display("FAIL lw: Imm=%h ResSrc=%b ALUSrc=%b MemW=%b RegW=%b, required FFFFFFFC/01/1/0/1",
                     ImmExtE, ResultSrcE, ALUSrcE, MemWriteE, RegWriteE);
        end
        cycle(32'hFE208CE3, 32'h304);
        checks++;
        if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || ImmExtE !== 32'hFFFFFFF8 || RegWriteE !== 1'b0
            || JumpE !== 1'b0 || ALUSrcE !== 1'b0) begin
            errors++;
            $display("FAIL beq: Branch=%b ALU=%b Imm=%h RegW=%b, required 1/001/FFFFFFF8/0",
                     BranchE, ALUControlE, ImmExtE, RegWriteE);
        end
        cycle(32'h010000EF, 32'h308);
        checks++;
        if (JumpE !== 1'b1 || ResultSrcE !== 2'b10 || ImmExtE !== 32'h00000010 || RegWriteE !== 1'b1
            || BranchE !== 1'b0) begin
            errors++;
            $display("FAIL jal: Jump=%b ResSrc=%b Imm=%h RegW=%b, required 1/10/00000010/1",
                     JumpE, ResultSrcE, ImmExtE, RegWriteE);
        end
        cycle(32'hFFF06413, 32'h30C);
        checks++;
        if (ALUControlE !== 3'b011 || ALUSrcE !== 1'b1 || ImmExtE !== 32'hFFFFFFFF || RDE !== 5'd8) begin
            errors++;
            $display("FAIL ori: ALU=%b ALUSrc=%b Imm=%h RDE=%0d, required 011/1/FFFFFFFF/8",
                     ALUControlE, ALUSrcE, ImmExtE, RDE);
        end
        cycle(32'h0052A493, 32'h310);
        checks++;
        if (ALUControlE !== 3'b101 || ImmExtE !== 32'd5 || RD1E !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL slti: ALU=%b Imm=%h RD1E=%h, required 101/5/DEADBEEF", ALUControlE, ImmExtE, RD1E);
        end
    endtask

    task automatic test_flush();
        cycle(32'h00112223, 32'h400);
        checks++;
        if (MemWriteE !== 1'b1 || ImmExtE !== 32'd4 || ALUSrcE !== 1'b1 || RegWriteE !== 1'b0) begin
            errors++;
            $display("FAIL sw: MemW=%b Imm=%h ALUSrc=%b RegW=%b, required 1/4/1/0",
                     MemWriteE, ImmExtE, ALUSrcE, RegWriteE);
        end
        FlushE = 1'b1;
        cycle(32'h00112223, 32'h404);
        checks++;
        if ({ctrlBits(), RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E} !== '0) begin
            errors++;
            $display("FAIL flush_sw: ctrl=%h Imm=%h RS1E=%0d PCE=%h, required all zero",
                     ctrlBits(), ImmExtE, RS1E, PCE);
        end
    endtask

    task automatic test_x0_illegal();
        RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'd1;
        cycle(32'h00000033, 32'h500);
        checks++;
        if (RD1E !== 32'd0 || RD2E !== 32'd0 || RegWriteE !== 1'b1) begin
            errors++;
            $display("FAIL x0_write_bypass: RD1E=%h RD2E=%h, required 0/0", RD1E, RD2E);
        end
        cycle(32'h00000033, 32'h504);
        checks++;
        if (RD1E !== 32'd0) begin
            errors++;
            $display("FAIL x0_stays_zero: RD1E=%h, required 0", RD1E);
        end
        cycle(32'hFFFFFFFF, 32'h508);
        checks++;
        if (ctrlBits() !== 12'd0 || ImmExtE !== 32'd0 || RDE !== 5'd31 || PCE !== 32'h508) begin
            errors++;
            $display("FAIL illegal_opcode: ctrl=%h Imm=%h RDE=%0d PCE=%h, required 0/0/31/508",
                     ctrlBits(), ImmExtE, RDE, PCE);
        end
    endtask

    task automatic test_flush_and_reset();
        cycle(32'h010000EF, 32'h600);
        rst = 1'b1; FlushE = 1'b1;
        cycle(32'h00112223, 32'h604);
        checks++;
        if ({ctrlBits(), RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E} !== '0) begin
            errors++;
            $display("FAIL flush_reset: ctrl=%h Imm=%h PCE=%h, required all zero", ctrlBits(), ImmExtE, PCE);
        end
        cycle(32'h00028333, 32'h608);
        checks++;
        if (RD1E !== 32'd0 || RDE !== 5'd6 || RegWriteE !== 1'b1) begin
            errors++;
            $display("FAIL reset_clears_regs: RD1E=%h RDE=%0d, required 0/6", RD1E, RDE);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_back_to_back();
        test_flush();
        test_x0_illegal();
        test_flush_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
